yj_basic_sync_filter: RTL and testbench

Multi-channel synchronizer and glitch filter for asynchronous single-bit inputs (buttons, external strobes, status lines) entering the CLK domain. Each channel passes through a parametrised-depth flip-flop synchronizer, then a consecutive-agreement filter that only accepts a new level after it has been stable for FILT cycles. Registered single-cycle rise/fall pulses are also produced. The block is the general replacement for the fixed two-stage synchronizer and sits at every asynchronous input boundary of the accelerator.

---
 rtl/yj_basic_sync_filter.sv | 86 ++++++++
 tb/tb_yj_basic_sync_filter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yj_basic_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : yj_basic_sync_filter
// Brief    : Per-channel N-flop synchronizer followed by a consecutive-agreement
//            glitch filter with registered rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
module yj_basic_sync_filter #(
    parameter int   CH     = 4,
    parameter int   STAGES = 2,
    parameter int   FILT   = 4,
    parameter logic RSTVAL = 1'b0
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [CH-1:0] din,
    output logic [CH-1:0] dout,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic          any_edge
);

    localparam int                 c_CNT_W    = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILT - 1);

    // Illegal depths must stop elaboration rather than be silently clamped.
    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("yj_basic_sync_filter: STAGES must be 2 or more");
        end
        if (FILT < 1) begin : g_bad_filt
            $error("yj_basic_sync_filter: FILT must be 1 or more");
        end
    endgenerate

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [STAGES-1:0]  r_sync;
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_dout;
        logic               r_rise;
        logic               r_fall;
        logic               w_ss;

        assign w_ss = r_sync[STAGES-1];

        // Only r_sync[0] samples the asynchronous pin; only r_sync[1] reads it.
        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                r_sync <= {STAGES{RSTVAL}};
            end else begin
                r_sync <= {r_sync[STAGES-2:0], din[g]};
            end
        end

        // A disagreement run must reach FILT cycles; any agreeing cycle clears it.
        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                r_cnt  <= '0;
                r_dout <= RSTVAL;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else if (w_ss == r_dout) begin
                r_cnt  <= '0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_cnt  <= '0;
                r_dout <= w_ss;
                r_rise <= w_ss;
                r_fall <= ~w_ss;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end
        end

        assign dout[g] = r_dout;
        assign rise[g] = r_rise;
        assign fall[g] = r_fall;
    end

    assign any_edge = |{rise, fall};

endmodule
`default_nettype wire

// File: tb/tb_yj_basic_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_yj_basic_sync_filter
// Brief    : Directed and randomized checks of yj_basic_sync_filter over four
//            parameter sets against a cycle model of the filter rule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_yj_basic_sync_filter;

    localparam int NI = 4;
    localparam int ST0 = 2, FI0 = 4, CH0 = 4;
    localparam int ST1 = 3, FI1 = 1, CH1 = 8;
    localparam int ST2 = 5, FI2 = 7, CH2 = 1;
    localparam int ST3 = 2, FI3 = 2, CH3 = 8;
    localparam int         P_ST   [NI] = '{ST0, ST1, ST2, ST3};
    localparam int         P_FI   [NI] = '{FI0, FI1, FI2, FI3};
    localparam logic       P_RV   [NI] = '{1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [7:0] P_MASK [NI] = '{8'h0F, 8'hFF, 8'h01, 8'hFF};

    typedef struct packed {
        logic [NI-1:0][7:0] dout;
        logic [NI-1:0][7:0] rise;
        logic [NI-1:0][7:0] fall;
        logic [NI-1:0]      any;
    } snap_t;

    logic           CLK, RSTn;
    logic [CH0-1:0] din0, dout0, rise0, fall0;
    logic [CH1-1:0] din1, dout1, rise1, fall1;
    logic [CH2-1:0] din2, dout2, rise2, fall2;
    logic [CH3-1:0] din3, dout3, rise3, fall3;
    logic           any0, any1, any2, any3;

    int    tests_run, tests_failed;
    logic  sb_en, rnd_en;
    snap_t exp_q[$], obs_q[$];

    logic [7:0] m_pipe [NI][8];
    logic [7:0] m_dout [NI];
    logic [7:0] m_rise [NI];
    logic [7:0] m_fall [NI];
    int         m_cnt  [NI][8];

    yj_basic_sync_filter #(.CH(CH0), .STAGES(ST0), .FILT(FI0), .RSTVAL(1'b0)) u0 (
        .CLK(CLK), .RSTn(RSTn), .din(din0), .dout(dout0), .rise(rise0), .fall(fall0), .any_edge(any0));
    yj_basic_sync_filter #(.CH(CH1), .STAGES(ST1), .FILT(FI1), .RSTVAL(1'b1)) u1 (
        .CLK(CLK), .RSTn(RSTn), .din(din1), .dout(dout1), .rise(rise1), .fall(fall1), .any_edge(any1));
    yj_basic_sync_filter #(.CH(CH2), .STAGES(ST2), .FILT(FI2), .RSTVAL(1'b0)) u2 (
        .CLK(CLK), .RSTn(RSTn), .din(din2), .dout(dout2), .rise(rise2), .fall(fall2), .any_edge(any2));
    yj_basic_sync_filter #(.CH(CH3), .STAGES(ST3), .FILT(FI3), .RSTVAL(1'b0)) u3 (
        .CLK(CLK), .RSTn(RSTn), .din(din3), .dout(dout3), .rise(rise3), .fall(fall3), .any_edge(any3));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int j = 0; j < 8; j++) m_pipe[k][j] = P_RV[k] ? 8'hFF : 8'h00;
            for (int c = 0; c < 8; c++) m_cnt[k][c] = 0;
            m_dout[k] = P_RV[k] ? 8'hFF : 8'h00;
            m_rise[k] = 8'h00;
            m_fall[k] = 8'h00;
        end
    endtask

    // Disagreement of the synchronized level must persist FILT edges to be accepted.
    task automatic model_step();
        logic [7:0] d [NI];
        logic [7:0] ss;
        d[0] = {4'b0, din0};
        d[1] = din1;
        d[2] = {7'b0, din2};
        d[3] = din3;
        for (int k = 0; k < NI; k++) begin
            ss = m_pipe[k][P_ST[k]-1];
            for (int j = 7; j > 0; j--) m_pipe[k][j] = m_pipe[k][j-1];
            m_pipe[k][0] = d[k];
            for (int c = 0; c < 8; c++) begin
                m_rise[k][c] = 1'b0;
                m_fall[k][c] = 1'b0;
                if (ss[c] == m_dout[k][c]) begin
                    m_cnt[k][c] = 0;
                end else if (m_cnt[k][c] == P_FI[k] - 1) begin
                    m_dout[k][c] = ss[c];
                    m_rise[k][c] = ss[c];
                    m_fall[k][c] = ~ss[c];
                    m_cnt[k][c]  = 0;
                end else begin
                    m_cnt[k][c] = m_cnt[k][c] + 1;
                end
            end
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        for (int k = 0; k < NI; k++) begin
            s.dout[k] = m_dout[k] & P_MASK[k];
            s.rise[k] = m_rise[k] & P_MASK[k];
            s.fall[k] = m_fall[k] & P_MASK[k];
            s.any[k]  = |((m_rise[k] | m_fall[k]) & P_MASK[k]);
        end
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.dout = {dout3, {7'b0, dout2}, dout1, {4'b0, dout0}};
        s.rise = {rise3, {7'b0, rise2}, rise1, {4'b0, rise0}};
        s.fall = {fall3, {7'b0, fall2}, fall1, {4'b0, fall0}};
        s.any  = {any3, any2, any1, any0};
        return s;
    endfunction

    task automatic randomize_din();
        for (int c = 0; c < CH0; c++) if ($urandom_range(0, 5) == 0)  din0[c] = ~din0[c];
        for (int c = 0; c < CH1; c++) if ($urandom_range(0, 2) == 0)  din1[c] = ~din1[c];
        for (int c = 0; c < CH2; c++) if ($urandom_range(0, 11) == 0) din2[c] = ~din2[c];
        for (int c = 0; c < CH3; c++) if ($urandom_range(0, 3) == 0)  din3[c] = ~din3[c];
    endtask

    // One rising edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge CLK);
        if (!RSTn) model_reset();
        else       model_step();
        #1;
        if (sb_en) begin
            exp_q.push_back(model_snap());
            obs_q.push_back(dut_snap());
        end
        if (rnd_en) randomize_din();
    endtask

    task automatic test_reset();
        repeat (3) begin
            tick();
            tests_run++;
            if (dout0 !== 4'h0 || rise0 !== 4'h0 || fall0 !== 4'h0 || any0 !== 1'b0 || dout1 !== 8'hFF) begin
                tests_failed++;
                $display("FAIL reset_hold: dout0=%h rise0=%h fall0=%h any0=%b dout1=%h, want 0/0/0/0/ff",
                         dout0, rise0, fall0, any0, dout1);
            end
        end
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (8) tick();
        din0 = 4'hF;
        repeat (3) tick();
        #2;
        RSTn = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (dout0 !== 4'h0 || rise0 !== 4'h0 || fall0 !== 4'h0 || any0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: dout0=%h rise0=%h fall0=%h any0=%b, want all 0", dout0, rise0, fall0, any0);
        end
        repeat (2) begin
            tick();
            tests_run++;
            if (dout0 !== 4'h0 || rise0 !== 4'h0 || any0 !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_mid: dout0=%h rise0=%h any0=%b, want 0", dout0, rise0, any0);
            end
        end
        @(negedge CLK);
        RSTn = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            tests_run++;
            if (rise0 !== ((e == ST0 + FI0) ? 4'hF : 4'h0) || dout0 !== ((e >= ST0 + FI0) ? 4'hF : 4'h0)) begin
                tests_failed++;
                $display("FAIL reset_release e=%0d: rise0=%h dout0=%h, want %h %h", e, rise0, dout0,
                         (e == ST0 + FI0) ? 4'hF : 4'h0, (e >= ST0 + FI0) ? 4'hF : 4'h0);
            end
        end
        din0 = 4'h0;
        repeat (10) tick();
    endtask

    task automatic test_latency();
        logic exp_r, exp_d;
        din0 = 4'b0001;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_r = (e == ST0 + FI0);
            exp_d = (e >= ST0 + FI0);
            tests_run++;
            if (rise0[0] !== exp_r || dout0[0] !== exp_d || any0 !== exp_r || fall0 !== 4'h0) begin
                tests_failed++;
                $display("FAIL latency e=%0d: rise0=%b dout0=%b any=%b fall0=%h, want %b %b %b 0",
                         e, rise0[0], dout0[0], any0, fall0, exp_r, exp_d, exp_r);
            end
        end
        din0 = 4'h0;
        repeat (10) tick();
    endtask

    task automatic test_glitch();
        int   nr, nf;
        logic seen_high;
        nr = 0;
        nf = 0;
        seen_high = 1'b0;
        for (int r = 0; r < 5; r++) begin
            for (int e = 0; e < 7; e++) begin
                din0[1] = (e < FI0 - 1);
                tick();
                tests_run++;
                if (dout0[1] !== 1'b0 || rise0[1] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL glitch_short r=%0d e=%0d: dout1=%b rise1=%b, want 0 0", r, e, dout0[1], rise0[1]);
                end
            end
        end
        for (int i = 0; i < 48; i++) begin
            din0[1] = (i < 40) && ((i % 8) < FI0);
            tick();
            if (rise0[1] === 1'b1) nr++;
            if (fall0[1] === 1'b1) nf++;
            if (dout0[1] === 1'b1) seen_high = 1'b1;
            tests_run++;
            if ((rise0[1] & fall0[1]) !== 1'b0) begin
                tests_failed++;
                $display("FAIL glitch_excl i=%0d: rise1=%b fall1=%b, want not both", i, rise0[1], fall0[1]);
            end
        end
        tests_run++;
        if (nr != 5 || nf != 5 || seen_high !== 1'b1 || dout0[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_accept: rises=%0d falls=%0d seen_high=%b dout=%b, want 5 5 1 0",
                     nr, nf, seen_high, dout0[1]);
        end
    endtask

    task automatic test_interrupted();
        for (int e = 1; e <= 18; e++) begin
            din0[2] = (e <= 2) || (e >= 4 && e <= 7);
            tick();
            tests_run++;
            if (rise0[2] !== (e == 3 + ST0 + FI0)) begin
                tests_failed++;
                $display("FAIL interrupted e=%0d: rise2=%b, want %b", e, rise0[2], (e == 3 + ST0 + FI0));
            end
        end
    endtask

    task automatic test_simultaneous();
        din0 = 4'b0101;
        repeat (10) tick();
        din0 = 4'b1010;
        for (int e = 1; e <= 8; e++) begin
            tick();
            tests_run++;
            if (rise0 !== ((e == ST0 + FI0) ? 4'b1010 : 4'b0000) ||
                fall0 !== ((e == ST0 + FI0) ? 4'b0101 : 4'b0000) || any0 !== (e == ST0 + FI0)) begin
                tests_failed++;
                $display("FAIL simultaneous e=%0d: rise=%b fall=%b any=%b", e, rise0, fall0, any0);
            end
        end
        din0 = 4'h0;
        repeat (10) tick();
    endtask

    task automatic test_back_to_back();
        for (int e = 1; e <= 12; e++) begin
            din0[3] = (e <= FI0);
            tick();
            tests_run++;
            if (rise0[3] !== (e == ST0 + FI0) || fall0[3] !== (e == ST0 + 2 * FI0)) begin
                tests_failed++;
                $display("FAIL back_to_back e=%0d: rise3=%b fall3=%b, want %b %b",
                         e, rise0[3], fall0[3], (e == ST0 + FI0), (e == ST0 + 2 * FI0));
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_sweep();
        snap_t e_s, o_s;
        sb_en  = 1'b1;
        rnd_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2;
                RSTn = 1'b0;
                model_reset();
                #1;
                e_s = model_snap();
                o_s = dut_snap();
                tests_run++;
                if (o_s !== e_s) begin
                    tests_failed++;
                    $display("FAIL sweep_reset: got %h want %h", o_s, e_s);
                end
            end
            if (i == 1503) begin
                @(negedge CLK);
                RSTn = 1'b1;
            end
            tick();
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e_s = exp_q.pop_front();
                o_s = obs_q.pop_front();
                for (int k = 0; k < NI; k++) begin
                    tests_run++;
                    if ({o_s.dout[k], o_s.rise[k], o_s.fall[k], o_s.any[k]} !==
                        {e_s.dout[k], e_s.rise[k], e_s.fall[k], e_s.any[k]}) begin
                        tests_failed++;
                        $display("FAIL sweep u%0d i=%0d: dout/rise/fall/any=%h/%h/%h/%b, want %h/%h/%h/%b",
                                 k, i, o_s.dout[k], o_s.rise[k], o_s.fall[k], o_s.any[k],
                                 e_s.dout[k], e_s.rise[k], e_s.fall[k], e_s.any[k]);
                    end
                end
            end
        end
        sb_en  = 1'b0;
        rnd_en = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        sb_en        = 1'b0;
        rnd_en       = 1'b0;
        RSTn         = 1'b0;
        din0 = '0;
        din1 = '0;
        din2 = '0;
        din3 = '0;
        model_reset();
        test_reset();
        test_latency();
        test_glitch();
        test_interrupted();
        test_simultaneous();
        test_back_to_back();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
